// File: rtl/pong_paddle_ctrl.sv
// pong_paddle_ctrl
//   Paddle position and game-state controller for Pong. Synchronises the
//   controller button pairs, edge-detects start/pause and runs the
//   IDLE/SERVE/PLAY/PAUSE state machine. Once per video frame it moves each
//   paddle with speed ramping and clamps it to the visible range.
//
//   Optional build macro: AI_P2_EN
//     defined   - player 2 paddle tracks ball_y; paddle2 buttons are ignored
//                 (other[1] still works as start/pause).
//     undefined - paddle2 buttons drive player 2; ball_y is unused.
module pong_paddle_ctrl #(
  parameter int Y_W          = 10,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_H     = 64,
  parameter int SPEED_MIN    = 2,
  parameter int SPEED_MAX    = 8,
  parameter int RAMP_FRAMES  = 16,
  parameter int SERVE_FRAMES = 60
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic [1:0]     paddle1,
  input  logic [1:0]     paddle2,
  input  logic [1:0]     other,
  input  logic           point_scored,
  input  logic [Y_W-1:0] ball_y,
  output logic [Y_W-1:0] p1_y,
  output logic [Y_W-1:0] p2_y,
  output logic [1:0]     state,
  output logic           serve_start
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_PAUSE = 2'd3;

  localparam int                  Y_MAX      = SCREEN_H - PADDLE_H;
  localparam logic [Y_W-1:0]      Y_TOP_LIM  = Y_W'(Y_MAX);
  localparam logic signed [Y_W:0] Y_MAX_S    = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W-1:0]      Y_CENTRE   = Y_W'(Y_MAX / 2);
  localparam logic [Y_W-1:0]      SPD_MIN    = Y_W'(SPEED_MIN);
  localparam logic [Y_W-1:0]      SPD_MAX    = Y_W'(SPEED_MAX);
  localparam int                  RC_W       = $clog2(RAMP_FRAMES + 1);
  localparam int                  SC_W       = $clog2(SERVE_FRAMES + 1);
  localparam logic [RC_W-1:0]     RAMP_LAST  = RC_W'(RAMP_FRAMES);
  localparam logic [SC_W-1:0]     SERVE_LOAD = SC_W'(SERVE_FRAMES);

  // Per-player motion state: position, last applied direction (button
  // encoding, 00 = none), frames held in that direction, current speed.
  typedef struct packed {
    logic [Y_W-1:0]  y;
    logic [1:0]      dir;
    logic [RC_W-1:0] held;
    logic [Y_W-1:0]  spd;
  } player_t;

  localparam player_t PLAYER_RST = '{y: Y_CENTRE, dir: 2'b00, held: '0, spd: '0};

  // Saturate a signed candidate position into 0..Y_MAX (never wraps).
  function automatic logic [Y_W-1:0] clamp_pos(input logic signed [Y_W:0] pos);
    logic [Y_W-1:0] res;
    if (pos < 0)             res = '0;
    else if (pos > Y_MAX_S)  res = Y_TOP_LIM;
    else                     res = pos[Y_W-1:0];
    return res;
  endfunction

  // One frame of button-driven motion. The first frame of a new direction
  // moves at SPD_MIN and counts as held frame 1; every RAMP_FRAMES held
  // frames the speed doubles up to SPD_MAX.
  function automatic player_t step_player(input player_t cur, input logic [1:0] btn);
    player_t             nxt;
    logic [1:0]          dir;
    logic [Y_W-1:0]      eff;
    logic [Y_W-1:0]      dbl;
    logic [RC_W-1:0]     held;
    logic signed [Y_W:0] base;
    logic signed [Y_W:0] delta;
    nxt   = cur;
    dir   = (btn == 2'b01 || btn == 2'b10) ? btn : 2'b00;
    eff   = (dir == cur.dir) ? cur.spd : SPD_MIN;
    held  = (dir == cur.dir) ? cur.held + RC_W'(1) : RC_W'(1);
    dbl   = eff << 1;
    base  = signed'({1'b0, cur.y});
    delta = signed'({1'b0, eff});
    nxt.dir = dir;
    if (dir == 2'b00) begin
      nxt.held = '0;
      nxt.spd  = SPD_MIN;
    end else begin
      nxt.y = clamp_pos((dir == 2'b01) ? base - delta : base + delta);
      if (held == RAMP_LAST) begin
        nxt.held = '0;
        nxt.spd  = (dbl >= SPD_MAX) ? SPD_MAX : dbl;
      end else begin
        nxt.held = held;
        nxt.spd  = eff;
      end
    end
    return nxt;
  endfunction

  // Synchroniser chain, packed as {other, paddle2, paddle1}.
  logic [5:0]      sync1_q, sync1_d;
  logic [5:0]      sync2_q, sync2_d;
  logic [1:0]      other_prev_q, other_prev_d;
  logic [1:0]      state_q, state_d;
  logic [SC_W-1:0] serve_cnt_q, serve_cnt_d;
  logic            serve_start_q, serve_start_d;
  player_t         p1_q, p1_d;
  player_t         p2_q, p2_d;

  logic [1:0] p1_btn;
  logic [1:0] p2_btn;
  logic [1:0] other_s;
  logic       start_evt;

  assign p1_btn    = sync2_q[1:0];
  assign p2_btn    = sync2_q[3:2];
  assign other_s   = sync2_q[5:4];
  // Simultaneous rising edges on both bits collapse into one event.
  assign start_evt = |(other_s & ~other_prev_q);

`ifdef AI_P2_EN
  logic signed [Y_W:0] ai_tgt_raw;
  logic [Y_W-1:0]      ai_tgt;
  logic [Y_W-1:0]      ai_next_y;
  logic                unused_p2_btn;

  assign unused_p2_btn = ^p2_btn;

  // AI tracker: step toward the clamped ball-centred target by at most SPD_MIN.
  always_comb begin
    ai_tgt_raw = signed'({1'b0, ball_y}) - (Y_W+1)'(PADDLE_H / 2);
    ai_tgt     = clamp_pos(ai_tgt_raw);
    if (ai_tgt > p2_q.y) begin
      ai_next_y = ((ai_tgt - p2_q.y) > SPD_MIN) ? p2_q.y + SPD_MIN : ai_tgt;
    end else begin
      ai_next_y = ((p2_q.y - ai_tgt) > SPD_MIN) ? p2_q.y - SPD_MIN : ai_tgt;
    end
  end
`else
  logic unused_ball_y;

  assign unused_ball_y = ^ball_y;
`endif

  // Synchroniser and edge-detect next-state.
  always_comb begin
    sync1_d      = {other, paddle2, paddle1};
    sync2_d      = sync1_q;
    other_prev_d = other_s;
  end

  // Game FSM, serve countdown and per-frame paddle motion.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    state_d       = state_q;
    serve_cnt_d   = serve_cnt_q;
    serve_start_d = 1'b0;
    p1_d          = p1_q;
    p2_d          = p2_q;

    if (frame_tick && (state_q == ST_SERVE || state_q == ST_PLAY)) begin
      p1_d = step_player(p1_q, p1_btn);
`ifdef AI_P2_EN
      p2_d.y = ai_next_y;
`else
      p2_d = step_player(p2_q, p2_btn);
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (start_evt) begin
          state_d     = ST_SERVE;
          serve_cnt_d = SERVE_LOAD;
          p1_d.y      = Y_CENTRE;
          p2_d.y      = Y_CENTRE;
        end
      end
      ST_SERVE: begin
        // The tick that brings the countdown to zero launches play.
        if (frame_tick) begin
          if (serve_cnt_q <= SC_W'(1)) begin
            state_d       = ST_PLAY;
            serve_cnt_d   = '0;
            serve_start_d = 1'b1;
          end else begin
            serve_cnt_d = serve_cnt_q - SC_W'(1);
          end
        end
      end
      ST_PLAY: begin
        // A point outranks a simultaneous pause request.
        if (point_scored) begin
          state_d     = ST_SERVE;
          serve_cnt_d = SERVE_LOAD;
        end else if (start_evt) begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        if (start_evt) state_d = ST_PLAY;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      other_prev_q  <= '0;
      state_q       <= ST_IDLE;
      serve_cnt_q   <= '0;
      serve_start_q <= 1'b0;
      p1_q          <= PLAYER_RST;
      p2_q          <= PLAYER_RST;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      other_prev_q  <= other_prev_d;
      state_q       <= state_d;
      serve_cnt_q   <= serve_cnt_d;
      serve_start_q <= serve_start_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
    end
  end

  assign p1_y        = p1_q.y;
  assign p2_y        = p2_q.y;
  assign state       = state_q;
  assign serve_start = serve_start_q;

endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// tb_pong_paddle_ctrl: directed vectors, hand-written corner sequences and a
// randomized run checked against a frame-level behavioural model.
module tb_pong_paddle_ctrl;

  localparam int Y_MAX     = 416;
  localparam int CENTRE    = 208;
  localparam int SPEED_MIN = 2;
  localparam int SPEED_MAX = 8;
  localparam int RAMP      = 16;
  localparam int SERVE     = 60;
  localparam int HALF_PAD  = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       point_scored = 1'b0;
  logic [1:0] paddle1 = 2'b00;
  logic [1:0] paddle2 = 2'b00;
  logic [1:0] other = 2'b00;
  logic [9:0] ball_y = '0;
  logic [9:0] p1_y;
  logic [9:0] p2_y;
  logic [1:0] state;
  logic       serve_start;

  int total = 0;
  int bad   = 0;
  int ss_seen = 0;

  pong_paddle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .paddle1      (paddle1),
    .paddle2      (paddle2),
    .other        (other),
    .point_scored (point_scored),
    .ball_y       (ball_y),
    .p1_y         (p1_y),
    .p2_y         (p2_y),
    .state        (state),
    .serve_start  (serve_start)
  );

  always #5 clk = ~clk;

  // Count clocks on which serve_start is high.
  always @(posedge clk) if (serve_start === 1'b1) ss_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0] b1;
    logic [1:0] b2;
    int         frames;
    int         e1;
    int         e2;
  } vec_t;

  typedef struct {
    int y;
    int dir;
    int held;
    int spd;
  } mplayer_t;

  vec_t     vecs [9];
  mplayer_t m1, m2;
  int       m_state, m_left, m_ss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic press(input logic [1:0] which);
    @(negedge clk) other = which;
    wait_clks(4);
    other = 2'b00;
    wait_clks(3);
  endtask

  task automatic score();
    @(negedge clk) point_scored = 1'b1;
    @(negedge clk) point_scored = 1'b0;
  endtask

  task automatic set_btn(input logic [1:0] b1, input logic [1:0] b2);
    @(negedge clk);
    paddle1 = b1;
    paddle2 = b2;
    wait_clks(3);
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > Y_MAX) return Y_MAX;
    return v;
  endfunction

  // One frame of button motion, stated directly from the game rules.
  function automatic mplayer_t model_move(input mplayer_t p, input logic [1:0] btn);
    int d;
    d = (btn == 2'b01) ? -1 : (btn == 2'b10) ? 1 : 0;
    if (d == 0) begin
      p.dir = 0; p.held = 0; p.spd = SPEED_MIN;
      return p;
    end
    if (d != p.dir) begin
      p.spd = SPEED_MIN; p.held = 0;
    end
    p.y = clampi(p.y + d * p.spd);
    p.held++;
    if (p.held == RAMP) begin
      p.held = 0;
      p.spd  = (p.spd * 2 > SPEED_MAX) ? SPEED_MAX : p.spd * 2;
    end
    p.dir = d;
    return p;
  endfunction

  function automatic int model_ai(input int y, input int ball);
    int tgt;
    tgt = clampi(ball - HALF_PAD);
    if (tgt > y) return y + ((tgt - y > SPEED_MIN) ? SPEED_MIN : tgt - y);
    return y - ((y - tgt > SPEED_MIN) ? SPEED_MIN : y - tgt);
  endfunction

  task automatic model_frame();
    if (m_state == 1 || m_state == 2) begin
      m1 = model_move(m1, paddle1);
`ifdef AI_P2_EN
      m2.y = model_ai(m2.y, int'(ball_y));
`else
      m2 = model_move(m2, paddle2);
`endif
      if (m_state == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_state = 2;
          m_ss++;
        end
      end
    end
  endtask

  task automatic model_start();
    case (m_state)
      0: begin m_state = 1; m_left = SERVE; m1.y = CENTRE; m2.y = CENTRE; end
      2: m_state = 3;
      3: m_state = 2;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m1 = '{y: CENTRE, dir: 0, held: 0, spd: SPEED_MIN};
    m2 = '{y: CENTRE, dir: 0, held: 0, spd: SPEED_MIN};
    m_state = 0; m_left = 0; m_ss = 0;
  endtask

  initial begin
    int ss_base;
    int r;

    // Frame-batch vectors applied in PLAY: buttons, frame count, expected p1_y/p2_y.
    vecs[0] = '{b1: 2'b10, b2: 2'b01, frames: 16, e1: 240, e2: 176};
    vecs[1] = '{b1: 2'b10, b2: 2'b01, frames: 16, e1: 304, e2: 112};
    vecs[2] = '{b1: 2'b10, b2: 2'b01, frames: 2,  e1: 320, e2: 96};
    vecs[3] = '{b1: 2'b10, b2: 2'b01, frames: 14, e1: 416, e2: 0};
    vecs[4] = '{b1: 2'b11, b2: 2'b00, frames: 3,  e1: 416, e2: 0};
    vecs[5] = '{b1: 2'b01, b2: 2'b10, frames: 1,  e1: 414, e2: 2};
    vecs[6] = '{b1: 2'b00, b2: 2'b00, frames: 2,  e1: 414, e2: 2};
    vecs[7] = '{b1: 2'b01, b2: 2'b10, frames: 3,  e1: 408, e2: 8};
    vecs[8] = '{b1: 2'b10, b2: 2'b01, frames: 1,  e1: 410, e2: 6};

    #1 rst = 1'b1;
    wait_clks(3);
    check("reset_p1_y", p1_y, CENTRE);
    check("reset_p2_y", p2_y, CENTRE);
    check("reset_state", state, 0);
    check("reset_serve_start", serve_start, 0);
    @(negedge clk) rst = 1'b0;
    wait_clks(2);

    // Serve entry and countdown.
    press(2'b01);
    check("serve_entry_state", state, 1);
    repeat (SERVE - 1) frame();
    check("serve_before_last_tick", state, 1);
    check("serve_start_early", ss_seen, 0);
    frame();
    wait_clks(2);
    check("play_after_serve", state, 2);
    check("serve_start_pulse_count", ss_seen, 1);
    check("serve_no_motion_p1", p1_y, CENTRE);

    // Ramp, clamping and conflict vectors.
    for (int i = 0; i < 9; i++) begin
      set_btn(vecs[i].b1, vecs[i].b2);
      repeat (vecs[i].frames) frame();
      check($sformatf("vec%0d_p1_y", i), p1_y, vecs[i].e1);
`ifndef AI_P2_EN
      check($sformatf("vec%0d_p2_y", i), p2_y, vecs[i].e2);
`endif
    end

    // Pause freezes paddles; point ignored; resume without serve_start.
    press(2'b10);
    check("pause_state", state, 3);
    repeat (3) frame();
    check("pause_frozen_p1", p1_y, 410);
    score();
    wait_clks(2);
    check("pause_ignores_point", state, 3);
    press(2'b01);
    check("resume_state", state, 2);
    check("resume_no_serve_start", ss_seen, 1);

    // point_scored coincides with the start event: point wins.
    @(negedge clk) other = 2'b10;
    @(negedge clk);
    @(negedge clk) point_scored = 1'b1;
    @(negedge clk) point_scored = 1'b0;
    wait_clks(2);
    other = 2'b00;
    wait_clks(3);
    check("priority_point_wins", state, 1);
    press(2'b01);
    check("serve_ignores_start", state, 1);
    check("priority_no_serve_start", ss_seen, 1);

    // Asynchronous reset mid-serve, observed before any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_p1_y", p1_y, CENTRE);
    check("async_reset_p2_y", p2_y, CENTRE);
    check("async_reset_state", state, 0);
    check("async_reset_serve_start", serve_start, 0);
    paddle1 = 2'b00;
    paddle2 = 2'b00;
    @(negedge clk) rst = 1'b0;
    wait_clks(3);

    // Randomized run against the behavioural model.
    model_reset();
    ss_base = ss_seen;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 20) begin
        ball_y = 10'($urandom_range(0, 479));
        set_btn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end else if (r < 86) begin
        model_frame();
        frame();
      end else if (r < 95) begin
        model_start();
        press(2'($urandom_range(1, 3)));
      end else begin
        if (m_state == 2) begin m_state = 1; m_left = SERVE; end
        score();
      end
      check("rand_p1_y", p1_y, m1.y);
      check("rand_p2_y", p2_y, m2.y);
      check("rand_state", state, m_state);
    end
    wait_clks(2);
    check("rand_serve_start_count", ss_seen - ss_base, m_ss);

`ifdef AI_P2_EN
    // AI tracking: ball at line 100 pulls player 2 up to 68; paddle2 ignored.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    ball_y = 10'd100;
    set_btn(2'b00, 2'b10);
    press(2'b01);
    repeat (10) frame();
    check("ai_p2_after_10", p2_y, 188);
    repeat (60) frame();
    check("ai_p2_reached", p2_y, 68);
    repeat (5) frame();
    check("ai_p2_holds", p2_y, 68);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
